// File: rtl/data_mem_sized.sv
// Byte-addressed data memory for the MIPS load/store stage: sized stores with
// byte-lane enables, sign/zero-extended loads, misalign detection and optional clear.
module data_mem_sized #(
  parameter int DATA           = 32,
  parameter int ADDR           = 15,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clka,
  input  logic                        rsta,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [ADDR+$clog2(DATA/8)-1:0] req_addr,
  input  logic [DATA-1:0]             req_wdata,
  output logic                        rd_valid,
  output logic [DATA-1:0]             rd_data,
  output logic                        err_misalign,
  output logic                        busy
);

  localparam int LANES = DATA / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int DEPTH = 2 ** ADDR;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [ADDR-1:0]   cnt;
  logic [DATA-1:0]   mem [DEPTH];

  logic [ADDR-1:0]   idx;
  logic [OFF-1:0]    off;
  logic              accept;
  logic              legal;
  int                nbytes;
  logic [LANES-1:0]  lane_mask;
  logic [DATA-1:0]   wshift;
  logic [DATA-1:0]   shifted;
  logic              sign;
  logic [DATA-1:0]   load_ext;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready depends only on state, and nothing is held or queued while it is low.
  assign req_ready = (state == S_RUN);
  assign busy      = (state == S_CLEAR);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[ADDR+OFF-1:OFF];
  assign off       = req_addr[OFF-1:0];

  always_comb begin
    nbytes    = 1 << req_size;
    legal     = (int'(req_size) <= OFF) && ((int'(off) & (nbytes - 1)) == 0);
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(off) && i < int'(off) + nbytes) lane_mask[i] = 1'b1;
    end
    wshift  = req_wdata << {off, 3'b000};
    shifted = mem[idx] >> {off, 3'b000};
    sign    = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (j == nbytes - 1) sign = shifted[8*j+7];
    end
    for (int j = 0; j < LANES; j++) begin
      if (j < nbytes) load_ext[8*j +: 8] = shifted[8*j +: 8];
      else            load_ext[8*j +: 8] = req_unsigned ? 8'h00 : {8{sign}};
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state        <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt          <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      err_misalign <= 1'b0;
    end else begin
      rd_valid     <= 1'b0;
      err_misalign <= 1'b0;
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= S_RUN;
        end
        S_RUN: begin
          if (accept) begin
            if (!legal) begin
              err_misalign <= 1'b1;
              if (!req_we) begin
                rd_valid <= 1'b1;
                rd_data  <= '0;
              end
            end else if (!req_we) begin
              rd_valid <= 1'b1;
              rd_data  <= load_ext;
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Array has no reset; rsta is sampled as a level so a request coincident with reset is dropped.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (state == S_CLEAR) begin
        mem[cnt] <= '0;
      end else if (accept && legal && req_we) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_mask[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboarded bench for data_mem_sized: a 32-bit clearing instance and a
// 64-bit non-clearing instance, driven with directed vectors.
module tb_data_mem_sized;

  localparam int W = 98;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst, a_valid, a_ready, a_we, a_uns, a_rdv, a_err, a_busy;
  logic [1:0]  a_size;
  logic [5:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic        b_rst, b_valid, b_ready, b_we, b_uns, b_rdv, b_err, b_busy;
  logic [1:0]  b_size;
  logic [6:0]  b_addr;
  logic [63:0] b_wdata, b_rdata;

  data_mem_sized #(.DATA(32), .ADDR(4), .CLEAR_ON_RESET(1)) dut_a (
    .clka(clk), .rsta(a_rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr),
    .req_wdata(a_wdata), .rd_valid(a_rdv), .rd_data(a_rdata),
    .err_misalign(a_err), .busy(a_busy)
  );

  data_mem_sized #(.DATA(64), .ADDR(4), .CLEAR_ON_RESET(0)) dut_b (
    .clka(clk), .rsta(b_rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr),
    .req_wdata(b_wdata), .rd_valid(b_rdv), .rd_data(b_rdata),
    .err_misalign(b_err), .busy(b_busy)
  );

  // entry = {cycle, rd_valid, err_misalign, rd_data(64)}
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic req_a(input logic we, input logic [1:0] size, input logic uns,
                       input logic [5:0] addr, input logic [31:0] wdata,
                       input logic x_rdv, input logic x_err, input logic [31:0] x_data);
    a_valid = 1'b1; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata;
    if (x_rdv || x_err) exp_a.push_back({32'(cyc + 1), x_rdv, x_err, 32'h0, x_data});
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic req_b(input logic we, input logic [1:0] size, input logic uns,
                       input logic [6:0] addr, input logic [63:0] wdata,
                       input logic x_rdv, input logic x_err, input logic [63:0] x_data);
    b_valid = 1'b1; b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata;
    if (x_rdv || x_err) exp_b.push_back({32'(cyc + 1), x_rdv, x_err, x_data});
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (a_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n), 64'd16);
    chk({name, "_ready"}, 64'(a_ready), 64'd1);
  endtask

  logic [W-1:0] ga, ea, gb, eb;

  always @(negedge clk) begin
    if (a_rdv || a_err) begin
      ga = {32'(cyc), a_rdv, a_err, 32'h0, (a_rdv ? a_rdata : 32'h0)};
      n_vec++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected: got %h want no output", ga);
      end else begin
        ea = exp_a.pop_front();
        if (ga !== ea) begin
          n_fail++;
          $display("FAIL a_resp: got %h want %h", ga, ea);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rdv || b_err) begin
      gb = {32'(cyc), b_rdv, b_err, (b_rdv ? b_rdata : 64'h0)};
      n_vec++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected: got %h want no output", gb);
      end else begin
        eb = exp_b.pop_front();
        if (gb !== eb) begin
          n_fail++;
          $display("FAIL b_resp: got %h want %h", gb, eb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_we = 1'b0; a_size = 2'd0; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_we = 1'b0; b_size = 2'd0; b_uns = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("a_rst_busy",  64'(a_busy),  64'd1);
    chk("a_rst_ready", 64'(a_ready), 64'd0);
    chk("a_rst_rdv",   64'(a_rdv),   64'd0);
    chk("a_rst_rdata", 64'(a_rdata), 64'd0);
    chk("a_rst_err",   64'(a_err),   64'd0);
    chk("b_rst_busy",  64'(b_busy),  64'd0);
    chk("b_rst_ready", 64'(b_ready), 64'd1);
    a_rst = 1'b0; b_rst = 1'b0;
    count_clear("clear_len");

    // seed a word, then check a later clear really zeroes it
    req_a(1'b1, 2'd2, 1'b0, 6'h3C, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    req_a(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_data_hold", 64'(a_rdata), 64'hDEADBEEF);
    a_rst = 1'b1; #1;
    chk("rst_rdata_now", 64'(a_rdata), 64'd0);
    chk("rst_busy_now",  64'(a_busy),  64'd1);
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 0; i < 7; i++) req_a(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 1'b0, 1'b0, 32'h0);
    a_rst = 1'b1; #1;
    chk("midclr_busy",  64'(a_busy),  64'd1);
    chk("midclr_ready", 64'(a_ready), 64'd0);
    chk("midclr_rdv",   64'(a_rdv),   64'd0);
    @(negedge clk);
    a_rst = 1'b0;
    count_clear("clear_restart");
    req_a(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 1'b1, 1'b0, 32'h0);

    // extraction and extension, back-to-back loads
    req_a(1'b1, 2'd2, 1'b0, 6'h08, 32'h80FF7F01, 1'b0, 1'b0, 32'h0);
    req_a(1'b0, 2'd0, 1'b0, 6'h08, 32'h0, 1'b1, 1'b0, 32'h00000001);
    req_a(1'b0, 2'd0, 1'b0, 6'h0B, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80);
    req_a(1'b0, 2'd0, 1'b1, 6'h0B, 32'h0, 1'b1, 1'b0, 32'h00000080);
    req_a(1'b0, 2'd1, 1'b0, 6'h0A, 32'h0, 1'b1, 1'b0, 32'hFFFF80FF);
    req_a(1'b0, 2'd1, 1'b1, 6'h0A, 32'h0, 1'b1, 1'b0, 32'h000080FF);
    req_a(1'b0, 2'd0, 1'b0, 6'h09, 32'h0, 1'b1, 1'b0, 32'h0000007F);
    req_a(1'b0, 2'd0, 1'b0, 6'h0A, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF);

    // byte-lane store then immediate word load
    req_a(1'b1, 2'd2, 1'b0, 6'h08, 32'h11223344, 1'b0, 1'b0, 32'h0);
    req_a(1'b1, 2'd0, 1'b0, 6'h09, 32'hFFFFFFAA, 1'b0, 1'b0, 32'h0);
    chk("store_keeps_rdata", 64'(a_rdata), 64'hFFFFFFFF);
    req_a(1'b0, 2'd2, 1'b0, 6'h08, 32'h0, 1'b1, 1'b0, 32'h1122AA44);

    // misaligned and illegal-size requests
    req_a(1'b1, 2'd2, 1'b0, 6'h04, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    req_a(1'b0, 2'd1, 1'b0, 6'h05, 32'h0, 1'b1, 1'b1, 32'h0);
    req_a(1'b1, 2'd2, 1'b0, 6'h06, 32'h12345678, 1'b0, 1'b1, 32'h0);
    req_a(1'b0, 2'd2, 1'b0, 6'h04, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);
    req_a(1'b1, 2'd3, 1'b0, 6'h08, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0);
    req_a(1'b0, 2'd3, 1'b0, 6'h08, 32'h0, 1'b1, 1'b1, 32'h0);
    req_a(1'b0, 2'd2, 1'b1, 6'h08, 32'h0, 1'b1, 1'b0, 32'h1122AA44);

    // 64-bit instance: dword round trip and sub-word extraction
    req_b(1'b1, 2'd3, 1'b0, 7'h08, 64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h0);
    req_b(1'b0, 2'd3, 1'b0, 7'h08, 64'h0, 1'b1, 1'b0, 64'h0123456789ABCDEF);
    req_b(1'b0, 2'd2, 1'b1, 7'h0C, 64'h0, 1'b1, 1'b0, 64'h0000000001234567);
    req_b(1'b0, 2'd1, 1'b0, 7'h0E, 64'h0, 1'b1, 1'b0, 64'h0000000000000123);
    req_b(1'b0, 2'd0, 1'b0, 7'h0F, 64'h0, 1'b1, 1'b0, 64'h0000000000000001);
    req_b(1'b0, 2'd0, 1'b0, 7'h08, 64'h0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFEF);
    req_b(1'b0, 2'd2, 1'b0, 7'h08, 64'h0, 1'b1, 1'b0, 64'hFFFFFFFF89ABCDEF);
    req_b(1'b0, 2'd2, 1'b0, 7'h0A, 64'h0, 1'b1, 1'b1, 64'h0);

    // requests coincident with reset are dropped
    b_rst = 1'b1; #1;
    chk("b_rst_busy2",  64'(b_busy),  64'd0);
    chk("b_rst_ready2", 64'(b_ready), 64'd1);
    chk("b_rst_rdata",  b_rdata,      64'd0);
    req_b(1'b1, 2'd3, 1'b0, 7'h08, 64'h0, 1'b0, 1'b0, 64'h0);
    req_b(1'b0, 2'd3, 1'b0, 7'h08, 64'h0, 1'b0, 1'b0, 64'h0);
    b_rst = 1'b0;
    req_b(1'b0, 2'd3, 1'b0, 7'h08, 64'h0, 1'b1, 1'b0, 64'h0123456789ABCDEF);

    repeat (3) @(negedge clk);
    chk("a_queue_empty", 64'(exp_a.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
